ifu_fetch_way0: RTL and testbench

Way-0 instruction fetch stage, directly downstream of the way-0 PC unit.
- Accepts fetch addresses over a valid/ready handshake and issues them to instruction memory over a req/gnt channel.
- Collects in-order 64-bit responses (two instructions per fetch) into an output FIFO for decode.
- On a jump, discards all in-flight and buffered fetches.

---
 rtl/ifu_fetch_way0.sv | 169 ++++++++++++++++
 tb/tb_ifu_fetch_way0.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_way0.sv
`default_nettype none
// ============================================================================
// ifu_fetch_way0 : way-0 fetch stage; credit-limited imem requests, in-order
//                  responses tagged with their address into a decode FIFO.
//                  Optional perf counters: define IFU_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
module ifu_fetch_way0 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pc_valid_i,
  input  logic [ADDR_WIDTH-1:0] pc_addr_i,
  output logic                  pc_ready_o,
  input  logic                  flush_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic [DATA_WIDTH-1:0] inst_data_o,
  input  logic                  inst_ready_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
`endif
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAG_AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      kill;
  logic [CNT_W-1:0]      fifo_count;
  logic [FIFO_AW-1:0]    fifo_wr_ptr;
  logic [FIFO_AW-1:0]    fifo_rd_ptr;
  logic [TAG_AW-1:0]     tag_wr_ptr;
  logic [TAG_AW-1:0]     tag_rd_ptr;
  logic [ADDR_WIDTH-1:0] tag_mem       [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [31:0] in_flight;
  logic [31:0] occupancy;
  logic        credit;
  logic        accept;
  logic        resp_valid;
  logic        resp_live;
  logic        fifo_push;
  logic        fifo_pop;

  // Killed requests still hold FIFO credit until they return, so a later
  // live response can never find the FIFO full.
  always_comb begin
    in_flight = 32'(outstanding) + 32'(kill);
    occupancy = in_flight + 32'(fifo_count);
    credit    = (occupancy < 32'(FIFO_DEPTH)) && (in_flight < 32'(MAX_OUTSTANDING));
  end

  assign imem_req_o   = reset_n && pc_valid_i && credit && !flush_i;
  assign imem_addr_o  = reset_n ? pc_addr_i : '0;
  assign accept       = imem_req_o && imem_gnt_i;
  assign pc_ready_o   = accept;

  assign resp_valid   = imem_rvalid_i && (in_flight != 32'd0);
  assign resp_live    = resp_valid && (kill == '0);
  assign fifo_push    = resp_live && !flush_i;
  assign fifo_pop     = (fifo_count != '0) && inst_ready_i && !flush_i;

  assign inst_valid_o = (fifo_count != '0);
  assign inst_addr_o  = fifo_addr_mem[fifo_rd_ptr];
  assign inst_data_o  = fifo_data_mem[fifo_rd_ptr];

  function automatic logic [TAG_AW-1:0] tag_inc(input logic [TAG_AW-1:0] p);
    if (32'(p) == 32'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + TAG_AW'(1);
  endfunction

  // Killed requests are always the oldest in flight, so they retire first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      kill        <= '0;
    end else if (flush_i) begin
      outstanding <= '0;
      kill        <= outstanding + kill - OUT_W'(resp_valid);
    end else begin
      outstanding <= outstanding + OUT_W'(accept) - OUT_W'(resp_live);
      kill        <= kill - OUT_W'(resp_valid && !resp_live);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        tag_mem[tag_wr_ptr] <= pc_addr_i;
        tag_wr_ptr          <= tag_inc(tag_wr_ptr);
      end
      if (resp_valid) begin
        tag_rd_ptr <= tag_inc(tag_rd_ptr);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_mem[i] <= '0;
        fifo_data_mem[i] <= '0;
      end
    end else begin
      if (fifo_push) begin
        fifo_addr_mem[fifo_wr_ptr] <= tag_mem[tag_rd_ptr];
        fifo_data_mem[fifo_wr_ptr] <= imem_rdata_i;
      end
      if (flush_i) begin
        fifo_wr_ptr <= '0;
        fifo_rd_ptr <= '0;
        fifo_count  <= '0;
      end else begin
        if (fifo_push) begin
          fifo_wr_ptr <= fifo_wr_ptr + FIFO_AW'(1);
        end
        if (fifo_pop) begin
          fifo_rd_ptr <= fifo_rd_ptr + FIFO_AW'(1);
        end
        fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (fifo_pop) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      end
      if (pc_valid_i && !pc_ready_o) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_way0.sv
`default_nettype none
// Bench for ifu_fetch_way0: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the fetch stage.
module tb_ifu_fetch_way0;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [63:0] inst_data;
  logic        inst_ready;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: addresses in flight (oldest first), how many of the oldest
  // are killed, and the packets decode should see.
  logic [31:0] infl_q[$];
  pkt_t        fifo_q[$];
  int          kill_n  = 0;
  int          fetch_n = 0;
  int          stall_n = 0;
  bit          last_acc = 1'b0;

  ifu_fetch_way0 #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pc_valid_i(pc_valid), .pc_addr_i(pc_addr), .pc_ready_o(pc_ready),
    .flush_i(flush),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .inst_valid_o(inst_valid), .inst_addr_o(inst_addr), .inst_data_o(inst_data),
    .inst_ready_i(inst_ready)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf_fetch), .perf_stall_cnt_o(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit credit_now();
    return (infl_q.size() + fifo_q.size() < FIFO_DEPTH) && (infl_q.size() < MAX_OUT);
  endfunction

  // Model update on every active edge.
  initial begin
    bit   acc;
    bit   pop_ok;
    pkt_t p;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        infl_q.delete();
        fifo_q.delete();
        kill_n   = 0;
        fetch_n  = 0;
        stall_n  = 0;
        last_acc = 1'b0;
      end else begin
        acc    = pc_valid && credit_now() && !flush && imem_gnt;
        pop_ok = (fifo_q.size() > 0) && inst_ready && !flush;
        if (pc_valid && !acc) stall_n++;
        if (imem_rvalid && infl_q.size() > 0) begin
          p.addr = infl_q.pop_front();
          p.data = imem_rdata;
          if (kill_n > 0) kill_n--;
          else if (!flush) fifo_q.push_back(p);
        end
        if (pop_ok) begin
          void'(fifo_q.pop_front());
          fetch_n++;
        end
        if (flush) begin
          fifo_q.delete();
          kill_n = infl_q.size();
        end
        if (acc) infl_q.push_back(pc_addr);
        last_acc = acc;
      end
    end
  end

  // Per-cycle comparison against the model, 1 time unit after inputs change.
  initial begin
    bit exp_req;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        exp_req = pc_valid && credit_now() && !flush;
        chk("cmp_imem_req", imem_req, exp_req);
        chk("cmp_pc_ready", pc_ready, exp_req && imem_gnt);
        chk("cmp_imem_addr", imem_addr, pc_addr);
        chk("cmp_inst_valid", inst_valid, fifo_q.size() > 0);
        if (fifo_q.size() > 0) begin
          chk("cmp_inst_addr", inst_addr, fifo_q[0].addr);
          chk("cmp_inst_data", inst_data, fifo_q[0].data);
        end
`ifdef IFU_PERF_CNT_EN
        chk("cmp_perf_fetch", perf_fetch, 32'(fetch_n));
        chk("cmp_perf_stall", perf_stall, 32'(stall_n));
`endif
      end
    end
  end

  task automatic step(input bit pv, input logic [31:0] pa, input bit g, input bit rv,
                      input logic [63:0] rd, input bit fl, input bit rdy);
    @(negedge clk);
    pc_valid    = pv;
    pc_addr     = pa;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    flush       = fl;
    inst_ready  = rdy;
    #2;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, rdy);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_inst_valid"}, inst_valid, 64'h0);
    chk({tag, "_inst_addr"}, inst_addr, 64'h0);
    chk({tag, "_inst_data"}, inst_data, 64'h0);
    chk({tag, "_imem_req"}, imem_req, 64'h0);
    chk({tag, "_imem_addr"}, imem_addr, 64'h0);
    chk({tag, "_pc_ready"}, pc_ready, 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch, 64'h0);
    chk({tag, "_perf_stall"}, perf_stall, 64'h0);
`endif
  endtask

  task automatic single_fetch(input string tag);
    step(1'b1, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    chk({tag, "_accept"}, pc_ready, 64'h1);
    idle(1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    chk({tag, "_no_bypass"}, inst_valid, 64'h0);
    idle(1'b1);
    chk({tag, "_valid"}, inst_valid, 64'h1);
    chk({tag, "_addr"}, inst_addr, 64'h0);
    chk({tag, "_data"}, inst_data, 64'h1111_2222_3333_4444);
    idle(1'b0);
    chk({tag, "_drained"}, inst_valid, 64'h0);
  endtask

  initial begin
    logic [31:0] cur_addr;
    reset_n = 1'b0;
    pc_valid = 1'b1; pc_addr = 32'hDEAD_BEE8; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; flush = 1'b0; inst_ready = 1'b0;
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    pc_valid = 1'b0;
    reset_n  = 1'b1;

    single_fetch("single");

    // Back-to-back with decode stalled and a 1-cycle memory.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'(k < 4 ? 8 * k : 32'h20), 1'b1, (k >= 1 && k <= 4),
           {32'hCAFE_0000, 32'(8 * (k - 1))}, 1'b0, 1'b0);
      if (k >= 4) chk("bp_blocked", pc_ready, 64'h0);
      else        chk("bp_accept", pc_ready, 64'h1);
    end
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("bp_order_addr", inst_addr, 64'(8 * k));
      chk("bp_order_data", inst_data, {32'hCAFE_0000, 32'(8 * k)});
    end
    idle(1'b0);
    chk("bp_empty", inst_valid, 64'h0);

    // Grant withheld.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h40, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      chk("nognt_ready", pc_ready, 64'h0);
      chk("nognt_req", imem_req, 64'h1);
      chk("nognt_addr", imem_addr, 64'h40);
    end
    step(1'b1, 32'h40, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("gnt_ready", pc_ready, 64'h1);
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall_lit", perf_stall, 64'd5);
    chk("perf_fetch_lit", perf_fetch, 64'd5);
`endif
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'h4040_4040_0000_0040, 1'b0, 1'b0);
    idle(1'b1);
    chk("gnt_pkt_addr", inst_addr, 64'h40);
    chk("gnt_pkt_data", inst_data, 64'h4040_4040_0000_0040);

    // Flush with two requests in flight.
    step(1'b1, 32'h20, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("flush_noreq", imem_req, 64'h0);
    step(1'b1, 32'h100, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("kill_blocked", pc_ready, 64'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'hBAD0_0000_0000_0020, 1'b0, 1'b1);
    chk("kill_drop0", inst_valid, 64'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'hBAD0_0000_0000_0028, 1'b0, 1'b1);
    chk("kill_drop1", inst_valid, 64'h0);
    idle(1'b1);
    chk("kill_drop2", inst_valid, 64'h0);
    step(1'b1, 32'h100, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("post_kill_accept", pc_ready, 64'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'h0100_0100_0100_0100, 1'b0, 1'b0);
    idle(1'b1);
    chk("post_kill_valid", inst_valid, 64'h1);
    chk("post_kill_addr", inst_addr, 64'h100);
    chk("post_kill_data", inst_data, 64'h0100_0100_0100_0100);

    // Flush colliding with a response and a consume, FIFO holding two.
    step(1'b1, 32'h200, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 32'h208, 1'b1, 1'b1, 64'hD200, 1'b0, 1'b0);
    step(1'b1, 32'h210, 1'b1, 1'b1, 64'hD208, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'hD210, 1'b1, 1'b1);
    chk("fl_pre_valid", inst_valid, 64'h1);
    chk("fl_pre_addr", inst_addr, 64'h200);
    idle(1'b1);
    chk("fl_cleared", inst_valid, 64'h0);
    idle(1'b1);
    chk("fl_resp_dropped", inst_valid, 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk("fl_perf_fetch", perf_fetch, 64'd7);
`endif

    // Asynchronous reset with two packets buffered.
    step(1'b1, 32'h300, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 32'h308, 1'b1, 1'b1, 64'hE300, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'hE308, 1'b0, 1'b0);
    chk("rst_pre_valid", inst_valid, 64'h1);
    @(negedge clk);
    pc_valid = 1'b1; pc_addr = 32'h3F0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    pc_valid = 1'b0;
    reset_n  = 1'b1;
    single_fetch("after_rst");

    // Random traffic.
    cur_addr = 32'hFFFF_FFD0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (flush)         cur_addr = $urandom & 32'hFFFF_FFF8;
      else if (last_acc) cur_addr = cur_addr + 32'd8;
      pc_valid    = ($urandom_range(3) != 0);
      pc_addr     = cur_addr;
      imem_gnt    = ($urandom_range(3) != 0);
      flush       = ($urandom_range(24) == 0);
      inst_ready  = ($urandom_range(2) != 0);
      imem_rvalid = (infl_q.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      imem_rdata  = {$urandom, $urandom};
    end
    idle(1'b1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
